x_y_grant_fsm: RTL and testbench
================================

# x_y_grant_fsm

Parametrised motor-enable controller for the x/y sensor interface. After reset release it pulses `f` for a programmable number of cycles, watches `x` for a programmable bit pattern with overlap, then opens a `g` grant window in which `y` must be seen to keep `g` asserted. It is the successor to the fixed 101/two-cycle controller and adds pattern, window and pulse-width parameters, a re-arm input and pass/fail status.

## Interface
- `PAT_LEN`, default 3: pattern length in bits, 1..16.
- `PATTERN`, default 3'b101: pattern on `x`, MSB first in time (MSB is the oldest sample).
- `Y_WINDOW`, default 2: cycles `g` is held while waiting for `y`, ≥1.
- `F_CYCLES`, default 1: width of the `f` pulse, ≥1.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `x`  in  1  pattern input, sampled every SEARCH cycle.
- `y`  in  1  confirmation input, sampled every WINDOW cycle.
- `rearm`  in  1  in PASS/FAIL: restart pattern search.
- `f`  out  1  high exactly during PULSE.
- `g`  out  1  high in WINDOW and PASS.
- `done`  out  1  high in PASS or FAIL.
- `pass`  out  1  high in PASS only.

## Operation
- States: IDLE, PULSE, SEARCH, WINDOW, PASS, FAIL.
- IDLE:
  - Entered asynchronously on `reset`.
  - Advances to PULSE on the first rising edge with `reset` low.
  - Never re-entered except by reset.
- PULSE: `f`=1 for exactly `F_CYCLES` cycles, then SEARCH. A cycle counter of width `$clog2(F_CYCLES+1)` is used.
- SEARCH:
  - Each cycle, shift `x` into history register `hist[PAT_LEN-1:0]` (new bit at LSB).
  - `fill` counts valid samples and saturates at `PAT_LEN`.
  - Match when `fill` is `PAT_LEN` after this shift and the shifted history equals `PATTERN`. The match is evaluated on the incoming `x`, so it completes on the same edge.
  - On match, the next state is WINDOW.
  - Overlap is inherent. With 101, `x` = 1,0,1,0,1 matches at sample 3.
  - Samples taken before SEARCH entry never contribute.
- WINDOW:
  - `g`=1. A counter runs for `Y_WINDOW` cycles.
  - If `y`=1 in any WINDOW cycle, go to PASS on that edge.
  - If the last WINDOW cycle ends with `y`=0, go to FAIL.
- PASS: `g`=1, `done`=1, `pass`=1. Holds.
- FAIL: `g`=0, `done`=1. Holds.
- `rearm`=1 in PASS or FAIL: the next state is SEARCH, with `hist` and `fill` cleared. `f` is not re-pulsed. `rearm` is ignored in all other states.
- Illegal state encodings recover to IDLE on the next edge.

## Timing
- Reset values: state IDLE; `f`, `g`, `done`, `pass` = 0; counters, `hist`, `fill` = 0.
- Outputs are Moore-decoded from registered state only. There is no combinational path from inputs to outputs.
- With defaults, after reset falls before edge 0:
  - edge 0 → PULSE (`f`=1 for one cycle).
  - edge 1 → SEARCH.
  - The first `x` sample is at edge 2.
- Final pattern bit sampled at edge k: `g`=1 from edge k.
- `y` sampled high at edge m within the window: PASS from edge m. `g` stays 1 without a gap.
- Window expiry: FAIL from edge k+`Y_WINDOW`, so `g` falls then.
- `rearm` sampled at edge r: SEARCH from edge r. The first pattern sample is taken at edge r+1.
- `reset` asserted mid-operation: all outputs drop to reset values immediately, without waiting for a clock edge.

## Structure
- Package `xy_fsm_pkg`:
  - `typedef enum logic [2:0]` `xy_state_t` {IDLE, PULSE, SEARCH, WINDOW, PASS, FAIL}.
  - Localparam helpers for counter widths.
- Sub-module `x_pattern_matcher`:
  - Parameters `PAT_LEN`, `PATTERN`.
  - Ports: `clk`, `reset`, `clear`, `en`, `x`, `match`.
  - Holds `hist` and `fill`. `match` is combinational from the next history value.
- Top level holds the state register, the PULSE and WINDOW counters, and output decode.

## Test plan
- Defaults; release reset; `x`=1,0,1 starting at edge 2; `y`=0,1 → `f`=1 for one cycle only, `g`=1 from edge 4 onward, PASS with `pass`=1, `done`=1.
- Defaults; `x`=1,0,1; `y`=0,0 → `g`=1 for exactly 2 cycles, then FAIL: `g`=0, `done`=1, `pass`=0, held for 20 cycles.
- Defaults; `x`=1,1,0,0,1,0,1 → no match at the 1,1,0 prefix; match on the final 1 only. Overlap check with `x`=1,0,1,0,1: exactly one WINDOW entry.
- `PAT_LEN`=4, `PATTERN`=4'b1101, `Y_WINDOW`=3, `F_CYCLES`=2 → `f` high for 2 cycles; `y` high on the 3rd window cycle gives PASS; `y` never high gives FAIL after 3 cycles.
- From FAIL, pulse `rearm` and drive `x`=0,1 (stale history) then 1,0,1 → no match from stale bits; match after the fresh 1,0,1; `f` stays 0.
- Assert `reset` asynchronously mid-WINDOW between clock edges → `g`, `f`, `done`, `pass` all 0 before the next edge; after release the sequence restarts with the `f` pulse.

Source files
------------

// File: rtl/xy_fsm_pkg.sv
// Shared types and width helpers for the x/y grant controller.
package xy_fsm_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PULSE  = 3'd1,
        SEARCH = 3'd2,
        WINDOW = 3'd3,
        PASS   = 3'd4,
        FAIL   = 3'd5
    } xy_state_t;

    // Bits needed to hold values 0..n (never less than one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/x_pattern_matcher.sv
// Overlapping serial pattern detector on x; match is judged on the incoming bit.
module x_pattern_matcher
    import xy_fsm_pkg::*;
#(
    parameter int unsigned          PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0]   PATTERN = 3'b101
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic en,
    input  logic x,
    output logic match
);

    localparam int unsigned FW = cnt_width(PAT_LEN);

    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FW-1:0]      fill_q, fill_d;

    // Shift in the new sample, saturate the fill count, compare post-shift.
    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        match  = 1'b0;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            hist_d = PAT_LEN'({hist_q, x});
            fill_d = (fill_q == FW'(PAT_LEN)) ? fill_q : fill_q + FW'(1);
            match  = (fill_d == FW'(PAT_LEN)) && (hist_d == PATTERN);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/x_y_grant_fsm.sv
// Motor-enable controller: f pulse, x pattern search, y-confirmed g grant window.
module x_y_grant_fsm
    import xy_fsm_pkg::*;
#(
    parameter int unsigned          PAT_LEN  = 3,
    parameter logic [PAT_LEN-1:0]   PATTERN  = 3'b101,
    parameter int unsigned          Y_WINDOW = 2,
    parameter int unsigned          F_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic x,
    input  logic y,
    input  logic rearm,
    output logic f,
    output logic g,
    output logic done,
    output logic pass
);

    localparam int unsigned PW = cnt_width(F_CYCLES);
    localparam int unsigned WW = cnt_width(Y_WINDOW);

    xy_state_t state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [WW-1:0] wcnt_q, wcnt_d;
    logic f_q, f_d, g_q, g_d, done_q, done_d, pass_q, pass_d;
    logic m_clear, m_en, m_match;

    x_pattern_matcher #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN)
    ) u_matcher (
        .clk   (clk),
        .reset (reset),
        .clear (m_clear),
        .en    (m_en),
        .x     (x),
        .match (m_match)
    );

    // Next-state, counter and matcher control; outputs follow next state so
    // the registered outputs always decode the registered state.
    always_comb begin
        state_d = state_q;
        pcnt_d  = pcnt_q;
        wcnt_d  = wcnt_q;
        m_clear = 1'b0;
        m_en    = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = PULSE;
                pcnt_d  = '0;
            end
            PULSE: begin
                if (pcnt_q == PW'(F_CYCLES - 1)) begin
                    state_d = SEARCH;
                    pcnt_d  = '0;
                    m_clear = 1'b1;
                end else begin
                    pcnt_d = pcnt_q + PW'(1);
                end
            end
            SEARCH: begin
                m_en = 1'b1;
                if (m_match) begin
                    state_d = WINDOW;
                    wcnt_d  = '0;
                end
            end
            WINDOW: begin
                if (y) begin
                    state_d = PASS;
                    wcnt_d  = '0;
                end else if (wcnt_q == WW'(Y_WINDOW - 1)) begin
                    state_d = FAIL;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d = wcnt_q + WW'(1);
                end
            end
            PASS, FAIL: begin
                if (rearm) begin
                    state_d = SEARCH;
                    m_clear = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                pcnt_d  = '0;
                wcnt_d  = '0;
            end
        endcase

        f_d    = (state_d == PULSE);
        g_d    = (state_d == WINDOW) || (state_d == PASS);
        done_d = (state_d == PASS) || (state_d == FAIL);
        pass_d = (state_d == PASS);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pcnt_q  <= '0;
            wcnt_q  <= '0;
            f_q     <= 1'b0;
            g_q     <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pcnt_q  <= pcnt_d;
            wcnt_q  <= wcnt_d;
            f_q     <= f_d;
            g_q     <= g_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
        end
    end

    assign f    = f_q;
    assign g    = g_q;
    assign done = done_q;
    assign pass = pass_q;

endmodule

// File: tb/tb_x_y_grant_fsm.sv
// Directed and random checks of two x_y_grant_fsm configurations against a behavioural model.
module tb_x_y_grant_fsm;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic x0 = 1'b0, y0 = 1'b0, r0 = 1'b0;
    logic x1 = 1'b0, y1 = 1'b0, r1 = 1'b0;
    logic f0, g0, d0, p0;
    logic f1, g1, d1, p1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    x_y_grant_fsm dut0 (
        .clk(clk), .reset(reset), .x(x0), .y(y0), .rearm(r0),
        .f(f0), .g(g0), .done(d0), .pass(p0)
    );

    x_y_grant_fsm #(
        .PAT_LEN(4), .PATTERN(4'b1101), .Y_WINDOW(3), .F_CYCLES(2)
    ) dut1 (
        .clk(clk), .reset(reset), .x(x1), .y(y1), .rearm(r1),
        .f(f1), .g(g1), .done(d1), .pass(p1)
    );

    // Behavioural model: phase name per instance, sample queues, countdowns.
    localparam int PH_RST = 0, PH_PULSE = 1, PH_SEEK = 2, PH_WIN = 3, PH_OK = 4, PH_BAD = 5;
    int ph[2];
    int left[2];
    int plen[2] = '{3, 4};
    int pat[2]  = '{5, 13};
    int win[2]  = '{2, 3};
    int fcy[2]  = '{1, 2};
    bit q0[$];
    bit q1[$];

    function automatic bit hit(input int i);
        int n;
        int v;
        n = (i == 0) ? q0.size() : q1.size();
        if (n < plen[i]) return 1'b0;
        v = 0;
        for (int j = 0; j < plen[i]; j++)
            v = v * 2 + int'((i == 0) ? q0[n - plen[i] + j] : q1[n - plen[i] + j]);
        return v == pat[i];
    endfunction

    task automatic clearq(input int i);
        if (i == 0) q0.delete(); else q1.delete();
    endtask

    task automatic mreset();
        for (int i = 0; i < 2; i++) begin
            ph[i] = PH_RST;
            left[i] = 0;
            clearq(i);
        end
    endtask

    task automatic mstep(input int i, input bit xi, input bit yi, input bit ri);
        case (ph[i])
            PH_RST: begin ph[i] = PH_PULSE; left[i] = fcy[i]; end
            PH_PULSE: begin
                left[i]--;
                if (left[i] == 0) begin ph[i] = PH_SEEK; clearq(i); end
            end
            PH_SEEK: begin
                if (i == 0) q0.push_back(xi); else q1.push_back(xi);
                if (hit(i)) begin ph[i] = PH_WIN; left[i] = win[i]; end
            end
            PH_WIN: begin
                if (yi) ph[i] = PH_OK;
                else begin
                    left[i]--;
                    if (left[i] == 0) ph[i] = PH_BAD;
                end
            end
            default: if (ri) begin ph[i] = PH_SEEK; clearq(i); end
        endcase
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("f0", 32'(f0), 32'(ph[0] == PH_PULSE));
        chk("g0", 32'(g0), 32'(ph[0] == PH_WIN || ph[0] == PH_OK));
        chk("done0", 32'(d0), 32'(ph[0] == PH_OK || ph[0] == PH_BAD));
        chk("pass0", 32'(p0), 32'(ph[0] == PH_OK));
        chk("f1", 32'(f1), 32'(ph[1] == PH_PULSE));
        chk("g1", 32'(g1), 32'(ph[1] == PH_WIN || ph[1] == PH_OK));
        chk("done1", 32'(d1), 32'(ph[1] == PH_OK || ph[1] == PH_BAD));
        chk("pass1", 32'(p1), 32'(ph[1] == PH_OK));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) mreset();
        else begin
            mstep(0, x0, y0, r0);
            mstep(1, x1, y1, r1);
        end
        #1;
        check_all();
    endtask

    task automatic t0(input logic xv, input logic yv);
        x0 = xv; y0 = yv;
        tick();
    endtask

    task automatic t1(input logic xv, input logic yv);
        x1 = xv; y1 = yv;
        tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        x0 = 0; y0 = 0; r0 = 0; x1 = 0; y1 = 0; r1 = 0;
        #1;
        mreset();
        tick();
        tick();
        reset = 1'b0;
    endtask

    int wins;
    logic g_prev;

    initial begin
        mreset();
        // Defaults: pulse, 1,0,1, y on second window cycle -> PASS
        do_reset();
        chk("rst_g0", 32'(g0), 0);
        tick();
        chk("t1_f_edge0", 32'(f0), 1);
        tick();
        chk("t1_f_edge1", 32'(f0), 0);
        chk("t1_f1_edge1", 32'(f1), 1);
        t0(1, 0); t0(0, 0); t0(1, 0);
        chk("t1_g_edge4", 32'(g0), 1);
        t0(0, 0); t0(0, 1);
        chk("t1_pass", 32'(p0), 1);
        repeat (4) t0(0, 0);
        chk("t1_pass_hold", 32'(g0), 1);

        // Defaults: y never seen -> FAIL held
        do_reset();
        tick(); tick();
        t0(1, 0); t0(0, 0); t0(1, 0); t0(0, 0);
        chk("t2_g_win2", 32'(g0), 1);
        t0(0, 0);
        chk("t2_fail_g", 32'(g0), 0);
        chk("t2_fail_done", 32'(d0), 1);
        repeat (20) t0(0, 1);
        chk("t2_fail_hold", 32'(d0), 1);
        chk("t2_fail_pass", 32'(p0), 0);

        // Rearm from FAIL: stale history must not match
        r0 = 1'b1;
        tick();
        r0 = 1'b0;
        chk("t5_rearm_done", 32'(d0), 0);
        t0(0, 0); t0(1, 0);
        chk("t5_no_stale", 32'(g0), 0);
        t0(1, 0); t0(0, 0); t0(1, 0);
        chk("t5_fresh_match", 32'(g0), 1);
        chk("t5_no_f", 32'(f0), 0);

        // Prefix 1,1,0 must not match; final 1 does
        do_reset();
        tick(); tick();
        t0(1, 0); t0(1, 0); t0(0, 0); t0(0, 0); t0(1, 0); t0(0, 0);
        chk("t3_no_prefix", 32'(g0), 0);
        t0(1, 0);
        chk("t3_match", 32'(g0), 1);
        t0(0, 1);

        // Overlap 1,0,1,0,1: exactly one window entry
        do_reset();
        tick(); tick();
        wins = 0; g_prev = 1'b0;
        for (int k = 0; k < 5; k++) begin
            t0(k % 2 == 0, 0);
            if (g0 && !g_prev) wins++;
            g_prev = g0;
        end
        chk("t3_overlap_entries", 32'(wins), 1);

        // Configured instance: 2-cycle pulse, 1101, y on 3rd window cycle
        do_reset();
        tick();
        chk("t4_f_c0", 32'(f1), 1);
        tick();
        chk("t4_f_c1", 32'(f1), 1);
        tick();
        chk("t4_f_c2", 32'(f1), 0);
        t1(1, 0); t1(1, 0); t1(0, 0); t1(1, 0);
        chk("t4_g", 32'(g1), 1);
        t1(0, 0); t1(0, 0); t1(0, 1);
        chk("t4_pass", 32'(p1), 1);
        do_reset();
        tick(); tick(); tick();
        t1(1, 0); t1(1, 0); t1(0, 0); t1(1, 0);
        t1(0, 0); t1(0, 0);
        chk("t4_win_last", 32'(g1), 1);
        t1(0, 0);
        chk("t4_fail_g", 32'(g1), 0);
        chk("t4_fail_done", 32'(d1), 1);

        // Asynchronous reset mid-window
        do_reset();
        tick(); tick();
        t0(1, 0); t0(0, 0); t0(1, 0);
        chk("t6_in_win", 32'(g0), 1);
        #2;
        reset = 1'b1;
        #1;
        mreset();
        chk("t6_async_g", 32'(g0), 0);
        chk("t6_async_f", 32'(f0), 0);
        chk("t6_async_done", 32'(d0), 0);
        chk("t6_async_pass", 32'(p0), 0);
        check_all();
        tick();
        reset = 1'b0;
        tick();
        chk("t6_restart_f", 32'(f0), 1);

        // Random stimulus on both instances
        do_reset();
        repeat (400) begin
            x0 = 1'($urandom); y0 = ($urandom % 4) == 0; r0 = ($urandom % 8) == 0;
            x1 = 1'($urandom); y1 = ($urandom % 4) == 0; r1 = ($urandom % 8) == 0;
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
